// File: rtl/perceptron_trainer.sv
// Training controller for a 2-input perceptron: presents samples, checks the
// threshold result and applies the perceptron learning rule to the weights.
module perceptron_trainer #(
    parameter int fp_integer_width = 4,
    parameter int fp_fract_width   = 12,
    parameter int DEPTH            = 8,
    parameter int LR_SHIFT         = 2,
    parameter int EPOCH_W          = 8,
    localparam int fp_width        = fp_integer_width + fp_fract_width,
    localparam int AW              = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic signed [fp_width-1:0] wr_x1,
    input  logic signed [fp_width-1:0] wr_x2,
    input  logic                       wr_target,
    input  logic [AW:0]                num_samples,
    input  logic [EPOCH_W-1:0]         max_epochs,
    input  logic                       start,
    output logic [fp_width-1:0]        IN1,
    output logic [fp_width-1:0]        IN2,
    input  logic [fp_width-1:0]        weight1,
    input  logic [fp_width-1:0]        weight2,
    input  logic                       result,
    output logic [fp_width-1:0]        weight1_new,
    output logic [fp_width-1:0]        weight2_new,
    output logic                       weight1_ld,
    output logic                       weight2_ld,
    output logic                       busy,
    output logic                       done,
    output logic                       converged,
    output logic [EPOCH_W-1:0]         epoch_count,
    output logic [AW:0]                err_count
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        PRESENT,
        EVAL,
        UPDATE,
        EPOCH_END,
        DONE
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [AW:0]          num_q, num_d;
    logic [EPOCH_W-1:0]   max_q, max_d;
    logic [AW:0]          err_cnt_q, err_cnt_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;
    logic [AW:0]          err_out_q, err_out_d;
    logic                 conv_q, conv_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 err_neg_q, err_neg_d;
    logic [fp_width-1:0]  in1_q, in1_d;
    logic [fp_width-1:0]  in2_q, in2_d;

    logic [fp_width-1:0]  mem_x1_q [DEPTH];
    logic [fp_width-1:0]  mem_x2_q [DEPTH];
    logic                 mem_t_q  [DEPTH];

    logic                 ld;
    logic [fp_width-1:0]  w1_new, w2_new;
    logic                 last_idx;
    logic                 bad_cfg;

    // Sample store has no reset; writes are only honoured while idle.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q) begin
            mem_x1_q[wr_addr] <= wr_x1;
            mem_x2_q[wr_addr] <= wr_x2;
            mem_t_q[wr_addr]  <= wr_target;
        end
    end

    // w +/- (x >>> LR_SHIFT), one guard bit, clamped to the signed range.
    function automatic logic [fp_width-1:0] upd(
        input logic [fp_width-1:0] w,
        input logic [fp_width-1:0] x,
        input logic                neg
    );
        logic signed [fp_width-1:0] d;
        logic [fp_width:0]          s;
        d = $signed(x) >>> LR_SHIFT;
        if (neg) begin
            s = {w[fp_width-1], w} - {d[fp_width-1], d};
        end else begin
            s = {w[fp_width-1], w} + {d[fp_width-1], d};
        end
        if (s[fp_width] != s[fp_width-1]) begin
            upd = s[fp_width] ? {1'b1, {(fp_width-1){1'b0}}}
                              : {1'b0, {(fp_width-1){1'b1}}};
        end else begin
            upd = s[fp_width-1:0];
        end
        return upd;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            num_q     <= '0;
            max_q     <= '0;
            err_cnt_q <= '0;
            epoch_q   <= '0;
            err_out_q <= '0;
            conv_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_neg_q <= 1'b0;
            in1_q     <= '0;
            in2_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            max_q     <= max_d;
            err_cnt_q <= err_cnt_d;
            epoch_q   <= epoch_d;
            err_out_q <= err_out_d;
            conv_q    <= conv_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_neg_q <= err_neg_d;
            in1_q     <= in1_d;
            in2_q     <= in2_d;
        end
    end

    assign last_idx = ({1'b0, idx_q} == num_q - (AW+1)'(1));
    assign bad_cfg  = (num_samples == '0)
                   || (num_samples > (AW+1)'(DEPTH))
                   || (max_epochs == '0);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        num_d     = num_q;
        max_d     = max_q;
        err_cnt_d = err_cnt_q;
        epoch_d   = epoch_q;
        err_out_d = err_out_q;
        conv_d    = conv_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_neg_d = err_neg_q;
        in1_d     = in1_q;
        in2_d     = in2_q;
        ld        = 1'b0;
        w1_new    = '0;
        w2_new    = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    num_d     = num_samples;
                    max_d     = max_epochs;
                    idx_d     = '0;
                    err_cnt_d = '0;
                    epoch_d   = '0;
                    err_out_d = '0;
                    conv_d    = 1'b0;
                    busy_d    = 1'b1;
                    if (bad_cfg) begin
                        conv_d  = (num_samples == '0);
                        state_d = DONE;
                    end else begin
                        state_d = INIT;
                    end
                end
            end
            INIT: begin
                ld      = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                in1_d   = mem_x1_q[idx_q];
                in2_d   = mem_x2_q[idx_q];
                state_d = EVAL;
            end
            EVAL: begin
                if (mem_t_q[idx_q] != result) begin
                    // target 0 with result 1 is err = -1
                    err_neg_d = result;
                    err_cnt_d = err_cnt_q + (AW+1)'(1);
                    state_d   = UPDATE;
                end else if (last_idx) begin
                    state_d = EPOCH_END;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = PRESENT;
                end
            end
            UPDATE: begin
                ld     = 1'b1;
                w1_new = upd(weight1, in1_q, err_neg_q);
                w2_new = upd(weight2, in2_q, err_neg_q);
                if (last_idx) begin
                    state_d = EPOCH_END;
                end else begin
                    idx_d   = idx_q + AW'(1);
                    state_d = PRESENT;
                end
            end
            EPOCH_END: begin
                epoch_d   = epoch_q + EPOCH_W'(1);
                err_out_d = err_cnt_q;
                if (err_cnt_q == '0) begin
                    conv_d  = 1'b1;
                    state_d = DONE;
                end else if (epoch_q + EPOCH_W'(1) == max_q) begin
                    state_d = DONE;
                end else begin
                    err_cnt_d = '0;
                    idx_d     = '0;
                    state_d   = PRESENT;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign IN1         = in1_q;
    assign IN2         = in2_q;
    assign weight1_new = w1_new;
    assign weight2_new = w2_new;
    assign weight1_ld  = ld;
    assign weight2_ld  = ld;
    assign busy        = busy_q;
    assign done        = done_q;
    assign converged   = conv_q;
    assign epoch_count = epoch_q;
    assign err_count   = err_out_q;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with a behavioural perceptron model.
module tb_perceptron_trainer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_x1, wr_x2;
    logic        wr_target;
    logic [3:0]  num_samples;
    logic [7:0]  max_epochs;
    logic        start, start_b;

    logic [15:0] IN1, IN2, w1_new, w2_new, pw1, pw2;
    logic        w1_ld, w2_ld, busy, done, converged, result;
    logic [7:0]  epoch_count;
    logic [3:0]  err_count;

    logic [15:0] b_IN1, b_IN2, b_w1_new, b_w2_new, b_pw1, b_pw2;
    logic        b_w1_ld, b_w2_ld, b_busy, b_done, b_conv, b_result;
    logic [7:0]  b_epoch;
    logic [3:0]  b_err;

    logic signed [32:0] psum, b_psum;

    int n_assert = 0;
    int n_fail   = 0;
    int ld_cnt, nz_cnt, bad_new, done_cnt, b_ld_cnt, cyc;
    logic [15:0] last_w1, last_w2, b_last_w1, b_last_w2;
    logic found;

    perceptron_trainer #(.LR_SHIFT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_target(wr_target),
        .num_samples(num_samples), .max_epochs(max_epochs), .start(start),
        .IN1(IN1), .IN2(IN2), .weight1(pw1), .weight2(pw2), .result(result),
        .weight1_new(w1_new), .weight2_new(w2_new),
        .weight1_ld(w1_ld), .weight2_ld(w2_ld),
        .busy(busy), .done(done), .converged(converged),
        .epoch_count(epoch_count), .err_count(err_count)
    );

    perceptron_trainer #(.LR_SHIFT(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_x1(wr_x1), .wr_x2(wr_x2), .wr_target(wr_target),
        .num_samples(num_samples), .max_epochs(max_epochs), .start(start_b),
        .IN1(b_IN1), .IN2(b_IN2), .weight1(b_pw1), .weight2(b_pw2),
        .result(b_result),
        .weight1_new(b_w1_new), .weight2_new(b_w2_new),
        .weight1_ld(b_w1_ld), .weight2_ld(b_w2_ld),
        .busy(b_busy), .done(b_done), .converged(b_conv),
        .epoch_count(b_epoch), .err_count(b_err)
    );

    // Perceptron models: weight registers plus sign of the dot product.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pw1 <= '0; pw2 <= '0; b_pw1 <= '0; b_pw2 <= '0;
        end else begin
            if (w1_ld)   pw1   <= w1_new;
            if (w2_ld)   pw2   <= w2_new;
            if (b_w1_ld) b_pw1 <= b_w1_new;
            if (b_w2_ld) b_pw2 <= b_w2_new;
        end
    end
    assign psum   = $signed(IN1) * $signed(pw1) + $signed(IN2) * $signed(pw2);
    assign b_psum = $signed(b_IN1) * $signed(b_pw1)
                  + $signed(b_IN2) * $signed(b_pw2);
    assign result   = ~psum[32];
    assign b_result = ~b_psum[32];

    always @(negedge clk) begin
        if (w1_ld) begin
            ld_cnt++;
            last_w1 = w1_new;
            last_w2 = w2_new;
            if (w1_new != 0 || w2_new != 0) nz_cnt++;
        end else if (w1_new != 0 || w2_new != 0) begin
            bad_new++;
        end
        if (done) done_cnt++;
        if (b_w1_ld) begin
            b_ld_cnt++;
            b_last_w1 = b_w1_new;
            b_last_w2 = b_w2_new;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] x1,
                      input logic [15:0] x2, input logic t);
        wr_en = 1'b1; wr_addr = a; wr_x1 = x1; wr_x2 = x2; wr_target = t;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [3:0] n, input logic [7:0] m);
        num_samples = n; max_epochs = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int c);
        c = 0;
        while (done !== 1'b1 && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic clr();
        ld_cnt = 0; nz_cnt = 0; b_ld_cnt = 0; done_cnt = 0;
        last_w1 = 16'h1234; last_w2 = 16'h1234;
        b_last_w1 = 16'h1234; b_last_w2 = 16'h1234;
    endtask

    initial begin
        bad_new = 0;
        clr();
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_x1 = '0; wr_x2 = '0;
        wr_target = 1'b0; num_samples = '0; max_epochs = '0;
        start = 1'b0; start_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_conv", {31'd0, converged}, 0);
        chk("rst_epoch", {24'd0, epoch_count}, 0);
        chk("rst_errc", {28'd0, err_count}, 0);
        chk("rst_in", {IN1, IN2}, 0);
        chk("rst_ld", {30'd0, w1_ld, w2_ld}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: converges after one update
        wr(3'd0, 16'h1000, 16'h0000, 1'b1);
        wr(3'd1, 16'h0000, 16'h1000, 1'b0);
        clr();
        go(4'd2, 8'd8);
        chk("t1_busy", {31'd0, busy}, 1);
        wait_done(100, cyc);
        chk("t1_cycles", cyc, 13);
        chk("t1_conv", {31'd0, converged}, 1);
        chk("t1_epoch", {24'd0, epoch_count}, 2);
        chk("t1_errc", {28'd0, err_count}, 0);
        chk("t1_ld_cnt", ld_cnt, 2);
        chk("t1_w1_new", {16'd0, last_w1}, 32'h0000);
        chk("t1_w2_new", {16'd0, last_w2}, 32'hF800);
        chk("t1_in_hold", {IN1, IN2}, 32'h0000_1000);
        @(negedge clk);
        chk("t1_done_pulse", {31'd0, done}, 0);

        // T2: write and start in the same idle cycle; never converges
        clr();
        wr_en = 1'b1; wr_addr = 3'd0; wr_x1 = '0; wr_x2 = '0; wr_target = 1'b0;
        num_samples = 4'd1; max_epochs = 8'd4; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_done(100, cyc);
        chk("t2_cycles", cyc, 18);
        chk("t2_conv", {31'd0, converged}, 0);
        chk("t2_epoch", {24'd0, epoch_count}, 4);
        chk("t2_errc", {28'd0, err_count}, 1);
        chk("t2_ld_cnt", ld_cnt, 5);
        chk("t2_nonzero_new", nz_cnt, 0);

        // T3: saturation on the LR_SHIFT=0 instance
        wr(3'd0, 16'h8000, 16'h0000, 1'b0);
        clr();
        num_samples = 4'd1; max_epochs = 8'd1; start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        cyc = 0;
        while (b_done !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        chk("t3_done_seen", {31'd0, b_done}, 1);
        chk("t3_cycles", cyc, 6);
        chk("t3_w1_sat", {16'd0, b_last_w1}, 32'h7FFF);
        chk("t3_w2_new", {16'd0, b_last_w2}, 32'h0000);
        chk("t3_conv", {31'd0, b_conv}, 0);
        chk("t3_epoch", {24'd0, b_epoch}, 1);
        chk("t3_errc", {28'd0, b_err}, 1);
        chk("t3_ld_cnt", b_ld_cnt, 2);

        // T4: degenerate configurations
        clr();
        go(4'd0, 8'd8);
        chk("t4_busy", {31'd0, busy}, 1);
        wait_done(10, cyc);
        chk("t4a_cycles", cyc, 1);
        chk("t4a_conv", {31'd0, converged}, 1);
        chk("t4a_epoch", {24'd0, epoch_count}, 0);
        chk("t4a_busy_off", {31'd0, busy}, 0);
        @(negedge clk);
        go(4'd9, 8'd8);
        wait_done(10, cyc);
        chk("t4b_cycles", cyc, 1);
        chk("t4b_conv", {31'd0, converged}, 0);
        @(negedge clk);
        go(4'd2, 8'd0);
        wait_done(10, cyc);
        chk("t4c_conv", {31'd0, converged}, 0);
        chk("t4_no_ld", ld_cnt, 0);

        // T5: writes and starts while busy are dropped
        @(negedge clk);
        wr(3'd0, 16'h1000, 16'h0000, 1'b1);
        wr(3'd1, 16'h0000, 16'h1000, 1'b0);
        clr();
        go(4'd2, 8'd8);
        wr_en = 1'b1; wr_addr = 3'd1; wr_x1 = '0; wr_x2 = '0; wr_target = 1'b1;
        num_samples = 4'd1; start = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
        wait_done(100, cyc);
        chk("t5_cycles", cyc, 12);
        chk("t5_conv", {31'd0, converged}, 1);
        chk("t5_epoch", {24'd0, epoch_count}, 2);
        chk("t5_w2_new", {16'd0, last_w2}, 32'hF800);
        repeat (3) @(negedge clk);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_done_low", {31'd0, done}, 0);

        // T6: reset during UPDATE, then a clean rerun
        clr();
        go(4'd2, 8'd8);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (!found) begin
                if (w2_ld === 1'b1 && w2_new === 16'hF800) found = 1'b1;
                else @(negedge clk);
            end
        end
        chk("t6_reach_update", {31'd0, found}, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_ld_off", {30'd0, w1_ld, w2_ld}, 0);
        chk("t6_new_off", {w1_new, w2_new}, 0);
        @(negedge clk);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_out", {IN1, IN2}, 0);
        chk("t6_stat", {19'd0, done, converged, epoch_count, err_count}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        clr();
        go(4'd2, 8'd8);
        wait_done(100, cyc);
        chk("t6_cycles", cyc, 13);
        chk("t6_conv", {31'd0, converged}, 1);
        chk("t6_epoch", {24'd0, epoch_count}, 2);
        chk("t6_w2_new", {16'd0, last_w2}, 32'hF800);

        chk("no_stray_weight_new", bad_new, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
